// File: rtl/digit_scan_ctrl_pkg.sv
// Shared widths, display constants and the anode decode used by the digit
// scan controller.
package digit_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;

  localparam logic [NUM_DIGITS-1:0] AN_BLANK = 4'b1111;
  localparam logic [NUM_DIGITS-1:0] AN_RESET = 4'b1110;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEL_W-1:0]   sel_t;

  // Active-low one-hot enable for the selected digit; all dark when disabled.
  function automatic logic [NUM_DIGITS-1:0] an_decode(input sel_t sel, input logic en);
    logic [NUM_DIGITS-1:0] one_hot;
    one_hot = NUM_DIGITS'(1) << sel;
    return en ? ~one_hot : AN_BLANK;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Bundle of write-port, scan-enable and display-facing signals of the digit
// scan controller.
//
// Handshake: there is none. wr_en is a single-cycle qualifier sampled on every
// rising edge (no ready/back-pressure); tick is a one-cycle strobe the
// controller raises on the last prescaler cycle of each scan step.
interface digit_scan_if;
  import digit_scan_ctrl_pkg::*;

  logic                  en;
  logic                  wr_en;
  logic [SEL_W-1:0]      wr_addr;
  logic [DIGIT_W-1:0]    wr_data;
  logic [DIGIT_W-1:0]    i0;
  logic [DIGIT_W-1:0]    i1;
  logic [DIGIT_W-1:0]    i2;
  logic [DIGIT_W-1:0]    i3;
  logic [SEL_W-1:0]      s;
  logic [NUM_DIGITS-1:0] an;
  logic                  tick;

  modport master (
    output en, wr_en, wr_addr, wr_data,
    input  i0, i1, i2, i3, s, an, tick
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data,
    output i0, i1, i2, i3, s, an, tick
  );

endinterface

// File: rtl/digit_scan_ctrl_tick_gen.sv
// Prescaler: counts enabled cycles modulo DIV and flags the last one.
// Holding en low freezes the count so a paused step resumes where it stopped.
module tick_gen #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit register file plus rotating scan select for a 4-digit multiplexed
// display; the external 4:1 mux picks i[s] while an lights the matching digit.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  digit_scan_if.slave  bus
);

  digit_t dig_q [NUM_DIGITS];
  digit_t dig_d [NUM_DIGITS];
  sel_t   s_q;
  sel_t   s_d;
  logic   tick;

  tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_d[i] = dig_q[i];
    end
    if (bus.wr_en) begin
      dig_d[bus.wr_addr] = bus.wr_data;
    end
    // tick already folds in en, so a frozen scan never advances s.
    s_d = tick ? s_q + SEL_W'(1) : s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_q[i] <= '0;
      end
      s_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_q[i] <= dig_d[i];
      end
      s_q <= s_d;
    end
  end

  assign bus.i0   = dig_q[0];
  assign bus.i1   = dig_q[1];
  assign bus.i2   = dig_q[2];
  assign bus.i3   = dig_q[3];
  assign bus.s    = s_q;
  assign bus.tick = tick;
  assign bus.an   = an_decode(s_q, bus.en);

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Upstream driver for the 4-bit 4:1 digit mux.
- Holds four 4-bit digit registers, written through a simple write port, and presents them on i0..i3.
- Generates the rotating 2-bit select s at a prescaled rate, plus an active-low one-hot digit-enable an[3:0] aligned with s.
- The mux output y, together with an, drives a time-multiplexed 4-digit display.

Parameters:
- DIV, 4: clock cycles per scan step; legal range 1..65535.
- CNT_W, 16: prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  scan enable; 0 freezes the scan and blanks the display.
- wr_en  in  1  digit register write strobe.
- wr_addr  in  2  digit register index (0..3).
- wr_data  in  4  digit value to write.
- i0  out  4  digit register 0, feeds mux i0.
- i1  out  4  digit register 1, feeds mux i1.
- i2  out  4  digit register 2, feeds mux i2.
- i3  out  4  digit register 3, feeds mux i3.
- s  out  2  scan select, feeds mux s.
- an  out  4  active-low one-hot digit enable.
- tick  out  1  one-cycle pulse marking the last prescaler cycle of a scan step.

Behaviour:
- Reset (rst=1 at a rising edge):
  - digit regs = 0, so i0..i3 = 4'h0.
  - prescaler cnt = 0, s = 2'b00.
  - rst has priority over wr_en and en in the same cycle.
- Outputs after reset:
  - an = 4'b1110 if en=1, 4'b1111 if en=0.
  - tick = 0.
- Write port:
  - wr_en=1 at an edge loads reg[wr_addr] <= wr_data; the new value is visible on the i-outputs the cycle after.
  - Writes are independent of en and of the scan state.
  - A write to the currently selected digit is allowed and simply changes y from the next cycle.
  - Only one register is written per cycle.
- Prescaler:
  - When en=1: cnt increments each cycle, and wraps to 0 after reaching DIV-1.
  - When en=0: cnt holds.
- tick:
  - Combinational: tick = en & (cnt == DIV-1).
  - DIV=1: tick is high on every cycle that en=1.
- Scan counter:
  - On an edge with tick=1, s <= s+1 mod 4 (3 wraps to 0).
  - Otherwise s holds.
- an:
  - Combinational: an = ~(4'b0001 << s) when en=1, else 4'b1111.
  - an therefore changes in the same cycle as s; there is no extra pipeline stage.
- Latency / period:
  - With en held high, s advances every DIV cycles.
  - A full scan of 4 digits takes 4*DIV cycles.
- en deasserted mid-step:
  - cnt and s freeze, an blanks at once.
  - On re-assertion the scan resumes from the frozen cnt; the step is not restarted.
- rst mid-scan: returns to s=0, cnt=0 on the next edge; digit contents are cleared.
- No state beyond cnt, s and the four digit regs. No handshake back from the mux (it is purely combinational).

Decomposition:
- Shared package: NUM_DIGITS=4, DIGIT_W=4, SEL_W=2, AN_BLANK=4'b1111, AN_RESET=4'b1110.
- Sub-module: tick_gen (parameters DIV, CNT_W; ports clk, rst, en, tick). Holds the prescaler counter and is reused by other timing blocks.
- Digit regs, scan counter and an decode stay in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1 and wr_en=1 -> i0..i3=0, s=0, an=4'b1110, tick=0; no write occurs.
- Scan rate: DIV=4, en=1 for 20 cycles after reset -> tick high on cycles 3, 7, 11, 15, 19; s sequence 0,1,2,3,0; an goes 1110, 1101, 1011, 0111, 1110.
- Writes: write 4'hA to addr 0, 4'h5 to addr 2, 4'hF to addr 3 -> next cycle i0=A, i1=0, i2=5, i3=F; mux y follows as s cycles.
- Freeze: drop en for 5 cycles at cnt=2, s=1 -> an=1111, s=1, cnt=2 held, tick=0; re-enable -> tick after exactly 1 more cycle, then s=2.
- DIV=1: en=1 -> s increments every cycle, tick constantly high, s wraps 3->0.
- Reset mid-scan with wr_en: at s=3, assert rst together with wr_en to addr 1 -> next cycle s=0, cnt=0, i1=0.
